// File: rtl/ppu_pattern_pkg.sv
// Shared pattern-mode encoding and colour constants for the PPU test-pattern source.
package ppu_pattern_pkg;

    typedef enum logic [2:0] {
        BORDER   = 3'd0,
        SOLID    = 3'd1,
        BARS     = 3'd2,
        GRADIENT = 3'd3,
        BOX      = 3'd4
    } pattern_mode_t;

    // Classic colour-bar order, left to right.
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
        24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000
    };

    localparam logic [23:0] BORDER_RGB = 24'hffffff;
    localparam logic [23:0] BOX_FG_RGB = 24'hffffff;
    localparam logic [23:0] BOX_BG_RGB = 24'h202020;

endpackage

// File: rtl/ppu_box_animator.sv
// Bouncing-box position for the moving-box pattern; steps once per frame boundary.
module ppu_box_animator #(
    parameter int unsigned SCREEN_WIDTH  = 256,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter int unsigned BOX_SIZE      = 16,
    parameter int unsigned XW            = 9,
    parameter int unsigned YW            = 9
) (
    input  logic          clk_p,
    input  logic          rst_p,
    input  logic          step,
    output logic [XW-1:0] bx,
    output logic [YW-1:0] by
);

    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH - BOX_SIZE);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT - BOX_SIZE);

    // 1 = moving towards larger coordinates
    logic dir_x;
    logic dir_y;

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            bx    <= '0;
            by    <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (step) begin
            if (dir_x && bx == X_MAX) begin
                dir_x <= 1'b0;
                bx    <= bx - XW'(1);
            end else if (!dir_x && bx == '0) begin
                dir_x <= 1'b1;
                bx    <= bx + XW'(1);
            end else begin
                bx    <= dir_x ? bx + XW'(1) : bx - XW'(1);
            end

            if (dir_y && by == Y_MAX) begin
                dir_y <= 1'b0;
                by    <= by - YW'(1);
            end else if (!dir_y && by == '0) begin
                dir_y <= 1'b1;
                by    <= by + YW'(1);
            end else begin
                by    <= dir_y ? by + YW'(1) : by - YW'(1);
            end
        end
    end

endmodule

// File: rtl/ppu_pattern_gen.sv
// PPU-domain test-pattern source: raster counters, frame bookkeeping and a
// registered RGB pattern stage one cycle behind px/py.
module ppu_pattern_gen
    import ppu_pattern_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 256,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter int unsigned FRAME_WIDTH   = 341,
    parameter int unsigned FRAME_HEIGHT  = 262,
    parameter int unsigned XW            = 9,
    parameter int unsigned YW            = 9,
    parameter logic [23:0] SOLID_RGB     = 24'h0000ff,
    parameter int unsigned BOX_SIZE      = 16
) (
    input  logic          clk_p,
    input  logic          rst_p,
    input  logic [2:0]    mode,
    input  logic          sync_frame,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic [23:0]   rgb,
    output logic          active,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
    localparam logic [XW-1:0] SW_X     = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0] SH_Y     = YW'(SCREEN_HEIGHT);
    localparam logic [XW-1:0] SW_LAST  = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] SH_LAST  = YW'(SCREEN_HEIGHT - 1);
    localparam logic [XW-1:0] BAR_LAST = XW'(SCREEN_WIDTH / 8 - 1);
    localparam logic [XW:0]   BOX_X    = (XW + 1)'(BOX_SIZE);
    localparam logic [YW:0]   BOX_Y    = (YW + 1)'(BOX_SIZE);

    logic [XW-1:0] px_nxt;
    logic [YW-1:0] py_nxt;
    logic          at_origin;
    logic          boundary;
    logic          counting;
    logic [2:0]    mode_q;
    logic [2:0]    bar_idx;
    logic [XW-1:0] bar_pix;
    logic [XW-1:0] bx;
    logic [YW-1:0] by;
    logic          in_screen;
    logic          in_box;
    logic [23:0]   rgb_d;

    // The first edge after reset parks the raster at (0,0) without counting a frame.
    always_comb begin
        px_nxt = '0;
        py_nxt = '0;
        if (counting && !sync_frame) begin
            if (px == X_LAST) begin
                px_nxt = '0;
                py_nxt = (py == Y_LAST) ? '0 : py + YW'(1);
            end else begin
                px_nxt = px + XW'(1);
                py_nxt = py;
            end
        end
    end

    assign at_origin = (px_nxt == '0) && (py_nxt == '0);
    assign boundary  = counting && at_origin;

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            px          <= '0;
            py          <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            mode_q      <= '0;
            counting    <= 1'b0;
            bar_idx     <= '0;
            bar_pix     <= '0;
        end else begin
            px          <= px_nxt;
            py          <= py_nxt;
            frame_start <= at_origin;
            counting    <= 1'b1;
            if (boundary)
                frame_cnt <= frame_cnt + 8'd1;
            if (at_origin)
                mode_q <= mode;

            // Bar index tracks px_nxt so it lines up with px in the pixel stage.
            if (px_nxt == '0) begin
                bar_idx <= '0;
                bar_pix <= '0;
            end else if (bar_pix == BAR_LAST) begin
                bar_pix <= '0;
                if (bar_idx != 3'd7)
                    bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pix <= bar_pix + XW'(1);
            end
        end
    end

    ppu_box_animator #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT),
        .BOX_SIZE     (BOX_SIZE),
        .XW           (XW),
        .YW           (YW)
    ) u_box (
        .clk_p(clk_p),
        .rst_p(rst_p),
        .step (boundary),
        .bx   (bx),
        .by   (by)
    );

    assign in_screen = (px < SW_X) && (py < SH_Y);
    assign in_box    = (px >= bx) && ({1'b0, px} < ({1'b0, bx} + BOX_X)) &&
                       (py >= by) && ({1'b0, py} < ({1'b0, by} + BOX_Y));

    always_comb begin
        rgb_d = '0;
        if (in_screen) begin
            case (mode_q)
                BORDER: begin
                    if (px == '0 || py == '0 || px == SW_LAST || py == SH_LAST)
                        rgb_d = BORDER_RGB;
                    else if (px[0] ^ py[0])
                        rgb_d = {px[7:0], py[7:0], 8'h00};
                end
                SOLID:    rgb_d = SOLID_RGB;
                BARS:     rgb_d = BAR_RGB[bar_idx];
                GRADIENT: rgb_d = {px[7:0], py[7:0], frame_cnt};
                BOX:      rgb_d = in_box ? BOX_FG_RGB : BOX_BG_RGB;
                default:  rgb_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            rgb    <= '0;
            active <= 1'b0;
        end else begin
            rgb    <= rgb_d;
            active <= in_screen;
        end
    end

endmodule

// File: tb/tb_ppu_pattern_gen.sv
// Self-checking bench for ppu_pattern_gen: scoreboarded pixel targets plus
// per-scenario checks of the raster counters and frame bookkeeping.
module tb_ppu_pattern_gen;

    localparam int FW = 341;
    localparam int FH = 262;

    logic        clk_p = 1'b0;
    logic        rst_p = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        sync_frame = 1'b0;
    logic [8:0]  px;
    logic [8:0]  py;
    logic [23:0] rgb;
    logic        active;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    ppu_pattern_gen #(
        .SCREEN_WIDTH (256),
        .SCREEN_HEIGHT(240),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .XW           (9),
        .YW           (9),
        .SOLID_RGB    (24'h0000ff),
        .BOX_SIZE     (16)
    ) dut (
        .clk_p      (clk_p),
        .rst_p      (rst_p),
        .mode       (mode),
        .sync_frame (sync_frame),
        .px         (px),
        .py         (py),
        .rgb        (rgb),
        .active     (active),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_p = ~clk_p;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
        logic        act;
        string       name;
    } tgt_t;

    int   checks = 0;
    int   errors = 0;
    int   n_bound = 0;
    int   fs_pulses = 0;
    tgt_t targets[$];
    tgt_t sb[$];
    bit   sb_due = 0;
    tgt_t mon_t;

    // Scoreboard: a target is pushed when the raster reaches it and
    // compared against rgb/active one cycle later.
    always @(posedge clk_p) begin
        #1;
        if (frame_start === 1'b1) fs_pulses++;
        if (sb_due) begin
            mon_t  = sb.pop_front();
            sb_due = 0;
            checks++;
            if (rgb !== mon_t.rgb || active !== mon_t.act) begin
                errors++;
                $display("FAIL %s: got rgb=%06h active=%0b, want rgb=%06h active=%0b",
                         mon_t.name, rgb, active, mon_t.rgb, mon_t.act);
            end
        end
        if (targets.size() != 0 && int'(px) == targets[0].x && int'(py) == targets[0].y) begin
            sb.push_back(targets.pop_front());
            sb_due = 1;
        end
    end

    task automatic add_tgt(input int x, input int y, input logic [23:0] c,
                           input logic a, input string nm);
        tgt_t t;
        t.x = x; t.y = y; t.rgb = c; t.act = a; t.name = nm;
        targets.push_back(t);
    endtask

    task automatic step();
        @(posedge clk_p);
        #2;
    endtask

    task automatic do_sync(input int k);
        sync_frame = 1'b1;
        repeat (k) step();
        sync_frame = 1'b0;
        n_bound += k;
    endtask

    task automatic goto(input int x, input int y, input int limit);
        int k = 0;
        while (!(int'(px) == x && int'(py) == y) && k < limit) begin
            step();
            k++;
        end
        checks++;
        if (!(int'(px) == x && int'(py) == y)) begin
            errors++;
            $display("FAIL goto(%0d,%0d): stuck at px=%0d py=%0d", x, y, px, py);
        end
    endtask

    function automatic void box_sim(input int n, input int maxp, output int p, output bit d);
        p = 0;
        d = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (d && p == maxp) begin
                d = 1'b0; p--;
            end else if (!d && p == 0) begin
                d = 1'b1; p++;
            end else begin
                p = d ? p + 1 : p - 1;
            end
        end
    endfunction

    task automatic test_reset();
        #1 rst_p = 1'b1;
        repeat (2) @(posedge clk_p);
        #2;
        checks++;
        if (px !== 9'd0 || py !== 9'd0 || frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: got px=%0d py=%0d fs=%0b fc=%0d, want all 0",
                     px, py, frame_start, frame_cnt);
        end
        checks++;
        if (rgb !== 24'h0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_pixel: got rgb=%06h active=%0b, want 0", rgb, active);
        end
        @(negedge clk_p);
        rst_p = 1'b0;
    endtask

    task automatic test_free_run();
        mode = 3'd0;
        add_tgt(2,   4,   24'h000000, 1'b1, "m0_2_4");
        add_tgt(3,   4,   24'h030400, 1'b1, "m0_3_4");
        add_tgt(0,   5,   24'hffffff, 1'b1, "m0_0_5");
        add_tgt(5,   6,   24'h050600, 1'b1, "m0_5_6");
        add_tgt(255, 7,   24'hffffff, 1'b1, "m0_255_7");
        add_tgt(300, 10,  24'h000000, 1'b0, "m0_300_10");
        add_tgt(10,  239, 24'hffffff, 1'b1, "m0_10_239");
        add_tgt(11,  240, 24'h000000, 1'b0, "m0_11_240");
        step();
        checks++;
        if (px !== 9'd0 || py !== 9'd0 || frame_start !== 1'b1 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL first_edge: got px=%0d py=%0d fs=%0b fc=%0d, want 0 0 1 0",
                     px, py, frame_start, frame_cnt);
        end
        fs_pulses = 0;
        repeat (FW * FH - 1) step();
        checks++;
        if (px !== 9'd340 || py !== 9'd261 || frame_cnt !== 8'd0 || fs_pulses != 0) begin
            errors++;
            $display("FAIL frame_end: got px=%0d py=%0d fc=%0d pulses=%0d, want 340 261 0 0",
                     px, py, frame_cnt, fs_pulses);
        end
        // sync on the natural wrap edge: one boundary only
        do_sync(1);
        checks++;
        if (px !== 9'd0 || py !== 9'd0 || frame_start !== 1'b1 ||
            frame_cnt !== 8'd1 || fs_pulses != 1) begin
            errors++;
            $display("FAIL wrap_sync: got px=%0d py=%0d fs=%0b fc=%0d pulses=%0d, want 0 0 1 1 1",
                     px, py, frame_start, frame_cnt, fs_pulses);
        end
    endtask

    task automatic test_resync();
        goto(100, 2, 1000);
        checks++;
        if (frame_cnt !== 8'd1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL pre_sync: got fc=%0d fs=%0b, want 1 0", frame_cnt, frame_start);
        end
        do_sync(1);
        checks++;
        if (px !== 9'd0 || py !== 9'd0 || frame_start !== 1'b1 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL resync: got px=%0d py=%0d fs=%0b fc=%0d, want 0 0 1 2",
                     px, py, frame_start, frame_cnt);
        end
        step();
        checks++;
        if (px !== 9'd1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL after_sync: got px=%0d fs=%0b, want 1 0", px, frame_start);
        end
        do_sync(3);
        checks++;
        if (px !== 9'd0 || py !== 9'd0 || frame_start !== 1'b1 || frame_cnt !== 8'(n_bound)) begin
            errors++;
            $display("FAIL sync_hold: got px=%0d py=%0d fs=%0b fc=%0d, want 0 0 1 %0d",
                     px, py, frame_start, frame_cnt, n_bound);
        end
    endtask

    task automatic test_bars_latch();
        mode = 3'd2;
        add_tgt(0,   0, 24'hffffff, 1'b1, "bar_0");
        add_tgt(31,  0, 24'hffffff, 1'b1, "bar_31");
        add_tgt(32,  0, 24'hffff00, 1'b1, "bar_32");
        add_tgt(40,  0, 24'hffff00, 1'b1, "bar_40");
        add_tgt(100, 0, 24'h00ff00, 1'b1, "bar_100");
        add_tgt(255, 0, 24'h000000, 1'b1, "bar_255");
        add_tgt(256, 0, 24'h000000, 1'b0, "bar_256");
        add_tgt(128, 1, 24'hff00ff, 1'b1, "bar_128");
        add_tgt(200, 1, 24'h0000ff, 1'b1, "bar_200");
        do_sync(1);
        goto(0, 2, 1000);
        mode = 3'd1;
        add_tgt(40,  2, 24'hffff00, 1'b1, "latch_hold_40");
        add_tgt(250, 2, 24'h000000, 1'b1, "latch_hold_250");
        goto(0, 3, 1000);
        add_tgt(0,   0, 24'h0000ff, 1'b1, "solid_0");
        add_tgt(5,   0, 24'h0000ff, 1'b1, "solid_5");
        add_tgt(300, 0, 24'h000000, 1'b0, "solid_300");
        do_sync(1);
        goto(0, 1, 1000);
        checks++;
        if (frame_cnt !== 8'(n_bound)) begin
            errors++;
            $display("FAIL bars_fc: got fc=%0d, want %0d", frame_cnt, n_bound);
        end
    endtask

    task automatic test_gradient_reserved();
        logic [7:0] fc;
        mode = 3'd3;
        fc = 8'(n_bound + 1);
        add_tgt(3,   1, {8'h03, 8'h01, fc}, 1'b1, "grad_3_1");
        add_tgt(255, 1, {8'hff, 8'h01, fc}, 1'b1, "grad_255_1");
        add_tgt(256, 1, 24'h000000, 1'b0, "grad_256_1");
        do_sync(1);
        goto(0, 2, 1000);
        mode = 3'd5;
        add_tgt(10,  0, 24'h000000, 1'b1, "rsvd_10");
        add_tgt(300, 0, 24'h000000, 1'b0, "rsvd_300");
        do_sync(1);
        goto(0, 1, 1000);
    endtask

    task automatic test_box();
        int bxe, bye;
        bit dxe, dye;
        mode = 3'd4;
        do_sync(240 - n_bound);
        box_sim(n_bound, 240, bxe, dxe);
        box_sim(n_bound, 224, bye, dye);
        checks++;
        if (int'(dut.u_box.bx) != bxe || int'(dut.u_box.by) != bye || dut.u_box.dir_x !== dxe) begin
            errors++;
            $display("FAIL box_240: got bx=%0d by=%0d dx=%0b, want %0d %0d %0b",
                     dut.u_box.bx, dut.u_box.by, dut.u_box.dir_x, bxe, bye, dxe);
        end
        do_sync(1);
        box_sim(n_bound, 240, bxe, dxe);
        box_sim(n_bound, 224, bye, dye);
        checks++;
        if (int'(dut.u_box.bx) != bxe || dut.u_box.dir_x !== dxe) begin
            errors++;
            $display("FAIL box_241: got bx=%0d dx=%0b, want %0d %0b",
                     dut.u_box.bx, dut.u_box.dir_x, bxe, dxe);
        end
        box_sim(449, 240, bxe, dxe);
        box_sim(449, 224, bye, dye);
        add_tgt(bxe,      bye - 1, 24'h202020, 1'b1, "box_above");
        add_tgt(bxe - 1,  bye,     24'h202020, 1'b1, "box_left");
        add_tgt(bxe,      bye,     24'hffffff, 1'b1, "box_corner");
        add_tgt(bxe + 15, bye,     24'hffffff, 1'b1, "box_right_in");
        add_tgt(bxe + 16, bye,     24'h202020, 1'b1, "box_right_out");
        do_sync(449 - n_bound);
        goto(0, bye + 1, 2000);
        checks++;
        if (frame_cnt !== 8'(n_bound)) begin
            errors++;
            $display("FAIL box_fc: got fc=%0d, want %0d", frame_cnt, 8'(n_bound));
        end
    endtask

    task automatic test_async_reset();
        goto(50, 2, 1000);
        #3 rst_p = 1'b1;
        #1;
        checks++;
        if (px !== 9'd0 || py !== 9'd0 || rgb !== 24'h0 || active !== 1'b0 ||
            frame_cnt !== 8'd0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got px=%0d py=%0d rgb=%06h act=%0b fc=%0d fs=%0b, want all 0",
                     px, py, rgb, active, frame_cnt, frame_start);
        end
        checks++;
        if (dut.mode_q !== 3'd0) begin
            errors++;
            $display("FAIL async_mode: got mode_q=%0d, want 0", dut.mode_q);
        end
        @(negedge clk_p);
        mode  = 3'd0;
        rst_p = 1'b0;
        step();
        checks++;
        if (px !== 9'd0 || py !== 9'd0 || frame_start !== 1'b1 || frame_cnt !== 8'd0 ||
            dut.u_box.bx !== 9'd0) begin
            errors++;
            $display("FAIL post_reset_edge: got px=%0d py=%0d fs=%0b fc=%0d bx=%0d, want 0 0 1 0 0",
                     px, py, frame_start, frame_cnt, dut.u_box.bx);
        end
        step();
        checks++;
        if (px !== 9'd1 || frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_run: got px=%0d fs=%0b fc=%0d, want 1 0 0",
                     px, frame_start, frame_cnt);
        end
    endtask

    task automatic test_drained();
        checks++;
        if (targets.size() != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drained: got %0d targets and %0d pending, want 0 0",
                     targets.size(), sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_resync();
        test_bars_latch();
        test_gradient_reserved();
        test_box();
        test_async_reset();
        test_drained();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
